spi_master: RTL and testbench
=============================

SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter: DIV_W, default 8, width of the SCLK half-period divider input.
REQ-002 clk  input  1  system clock; all logic rises on clk, single clock domain.
REQ-003 rst  input  1  reset, synchronous and active-low (asserted when 0).
REQ-004 ena  input  1  clock enable; when 0 all state, counters and outputs hold.
REQ-005 spi_clk_polarity  input  1  CPOL; SCLK idle level.
REQ-006 spi_clk_phase  input  1  CPHA; 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-007 div  input  DIV_W  SCLK half-period = div+1 enabled clk cycles.
REQ-008 start  input  1  transfer request, sampled in IDLE only.
REQ-009 bus_in  input  8  byte to transmit.
REQ-010 bus_out  output  8  last received byte.
REQ-011 busy  output  1  high from the cycle after accepted start until done.
REQ-012 done  output  1  one-cycle pulse at transfer end.
REQ-013 spi_clk  output  1  SCLK to slave.
REQ-014 spi_ss  output  1  slave select, active-low.
REQ-015 spi_out  output  1  MOSI.
REQ-016 spi_in  input  1  MISO.

Function
REQ-017 The FSM SHALL have states IDLE, SETUP, XFER, HOLD.
REQ-018 In IDLE with ena=1 and start=1, the block SHALL latch bus_in, spi_clk_polarity, spi_clk_phase and div, then enter SETUP next cycle; later changes of these inputs SHALL not affect the transfer in progress.
REQ-019 start while busy=1 SHALL be ignored.
REQ-020 In SETUP: spi_ss=0, spi_clk=CPOL, spi_out=latched bit 7; stay one half-period, then enter XFER.
REQ-021 In XFER, spi_clk SHALL toggle once per half-period, 16 edges total, MSB first.
REQ-022 CPHA=0: sample spi_in on odd (leading) edges, shift the next bit onto spi_out on even (trailing) edges, except after the 16th edge.
REQ-023 CPHA=1: shift onto spi_out on leading edges (first leading edge presents bit 7), sample spi_in on trailing edges.
REQ-024 After edge 16, spi_clk SHALL equal CPOL; HOLD SHALL last one half-period with spi_ss=0.
REQ-025 On HOLD exit: spi_ss=1, bus_out=received byte, done=1 for one cycle, busy=0, return to IDLE.
REQ-026 Total latency: done SHALL assert exactly 18*(div+1)+1 enabled cycles after the cycle start was accepted.
REQ-027 bus_out SHALL change only on done.
REQ-028 A start in the same cycle as done SHALL be ignored; back-to-back transfers SHALL have at least one IDLE cycle with spi_ss=1.

Reset
REQ-029 While rst=0 at a clk edge: state=IDLE, spi_ss=1, spi_clk=spi_clk_polarity input, spi_out=0, bus_out=8'h00, busy=0, done=0, counters=0.
REQ-030 Reset mid-transfer SHALL abort immediately without a done pulse; spi_ss SHALL rise on the next edge.
REQ-031 In IDLE, spi_clk SHALL track the live spi_clk_polarity input.

Structure
REQ-032 Package spi_pkg SHALL hold the FSM state enum and the constant SPI_EDGES=16.
REQ-033 The half-period timer SHALL be a sub-module spi_clk_div: a DIV_W-bit counter with enable, synchronous clear and a terminal-count pulse.

Verification
REQ-034 Mode 0, div=0, bus_in=8'hA5, MOSI looped to MISO -> bus_out=8'hA5, 16 SCLK edges, done 19 cycles after start.
REQ-035 Mode 3, div=3, slave model returns 8'h3C, bus_in=8'hC3 -> slave receives 8'hC3, bus_out=8'h3C, SCLK idles high, done 73 cycles after start.
REQ-036 Modes 1 and 2 with div=1 and a slave returning 8'h81 -> bus_out=8'h81; edge alignment is checked against CPHA.
REQ-037 ena low for 10 cycles mid-XFER -> spi_clk, spi_out and counters frozen; the result is unchanged and done is delayed by exactly 10 cycles.
REQ-038 rst=0 at edge 7 -> spi_ss=1 next cycle, no done, bus_out=8'h00; a following transfer completes correctly.
REQ-039 start held high continuously -> transfers are separated by at least one spi_ss=1 cycle; start during busy never corrupts data.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master: FSM state encoding and
// the number of SCLK edges in one byte transfer.
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_XFER  = 2'd2,
        ST_HOLD  = 2'd3
    } spi_state_t;

    localparam int SPI_EDGES = 16;
    localparam int EDGE_W    = $clog2(SPI_EDGES + 1);

    // Edges are numbered from 1; odd-numbered edges leave the idle level.
    function automatic logic edge_is_leading(input logic [EDGE_W-1:0] edge_num);
        return edge_num[0];
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Half-period timer: counts enabled cycles 0..div and pulses tc on the last
// one, so each tc marks the end of a (div+1)-cycle half-period.
module spi_clk_div #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             clr,
    input  logic [DIV_W-1:0] div,
    output logic             tc
);

    logic [DIV_W-1:0] cnt;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values, independent of process ordering.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (ena) begin
            if (clr || cnt == div) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign tc = ena && !clr && (cnt == div);

endmodule

// File: rtl/spi_master.sv
// Single-byte SPI master, all four CPOL/CPHA modes, MSB first, with a
// programmable SCLK half-period of div+1 enabled clk cycles.
module spi_master
    import spi_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             spi_clk_polarity,
    input  logic             spi_clk_phase,
    input  logic [DIV_W-1:0] div,
    input  logic             start,
    input  logic [7:0]       bus_in,
    output logic [7:0]       bus_out,
    output logic             busy,
    output logic             done,
    output logic             spi_clk,
    output logic             spi_ss,
    output logic             spi_out,
    input  logic             spi_in
);

    spi_state_t        state;
    spi_state_t        state_n;
    logic              cpha_q;
    logic [DIV_W-1:0]  div_q;
    logic [7:0]        tx_sh;
    logic [7:0]        rx_sh;
    logic [EDGE_W-1:0] edge_cnt;
    logic [EDGE_W-1:0] edge_num;
    logic              tc;
    logic              accept;
    logic              leading;
    logic              last_edge;
    logic              sample_now;
    logic              shift_now;

    // The timer is held cleared in IDLE so SETUP always starts a fresh half-period.
    spi_clk_div #(.DIV_W(DIV_W)) u_clk_div (
        .clk (clk),
        .rst (rst),
        .ena (ena),
        .clr (state == ST_IDLE),
        .div (div_q),
        .tc  (tc)
    );

    // A start coinciding with done is dropped, guaranteeing an idle gap.
    assign accept     = (state == ST_IDLE) && start && !done;
    assign edge_num   = edge_cnt + 1'b1;
    assign leading    = edge_is_leading(edge_num);
    assign last_edge  = (edge_num == EDGE_W'(SPI_EDGES));
    assign sample_now = cpha_q ? !leading : leading;
    assign shift_now  = cpha_q ? leading : (!leading && !last_edge);

    // NOTE: every combinational output gets a default before the case so
    // no path leaves it unassigned, which would infer a latch.
    always_comb begin
        state_n = state;
        unique case (state)
            ST_IDLE:  if (accept) state_n = ST_SETUP;
            ST_SETUP: if (tc) state_n = ST_XFER;
            ST_XFER:  if (tc && last_edge) state_n = ST_HOLD;
            ST_HOLD:  if (tc) state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= ST_IDLE;
            cpha_q   <= 1'b0;
            div_q    <= '0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            edge_cnt <= '0;
            bus_out  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            spi_clk  <= spi_clk_polarity;
            spi_ss   <= 1'b1;
            spi_out  <= 1'b0;
        end else if (ena) begin
            state <= state_n;
            done  <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    spi_clk  <= spi_clk_polarity;
                    edge_cnt <= '0;
                    if (accept) begin
                        cpha_q  <= spi_clk_phase;
                        div_q   <= div;
                        tx_sh   <= bus_in;
                        rx_sh   <= '0;
                        busy    <= 1'b1;
                        spi_ss  <= 1'b0;
                        spi_out <= bus_in[7];
                    end
                end
                ST_SETUP: begin
                end
                ST_XFER: begin
                    if (tc) begin
                        spi_clk  <= ~spi_clk;
                        edge_cnt <= edge_num;
                        if (sample_now) begin
                            rx_sh <= {rx_sh[6:0], spi_in};
                        end
                        // CPHA=1 re-presents the current MSB on its leading edge;
                        // CPHA=0 already showed it in SETUP and advances instead.
                        if (shift_now) begin
                            spi_out <= cpha_q ? tx_sh[7] : tx_sh[6];
                            tx_sh   <= {tx_sh[6:0], 1'b0};
                        end
                    end
                end
                ST_HOLD: begin
                    if (tc) begin
                        spi_ss  <= 1'b1;
                        spi_out <= 1'b0;
                        spi_clk <= spi_clk_polarity;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        bus_out <= rx_sh;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: cycle-level reference model, reactive
// SPI slave, directed mode/latency cases and randomized transfers.
module tb_spi_master;

    localparam int DIV_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             ena;
    logic             cpol;
    logic             cpha;
    logic [DIV_W-1:0] div;
    logic             start;
    logic [7:0]       bus_in;
    logic [7:0]       bus_out;
    logic             busy;
    logic             done;
    logic             spi_clk;
    logic             spi_ss;
    logic             spi_out;
    logic             spi_in;

    always #5 clk = ~clk;

    spi_master #(.DIV_W(DIV_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .ena              (ena),
        .spi_clk_polarity (cpol),
        .spi_clk_phase    (cpha),
        .div              (div),
        .start            (start),
        .bus_in           (bus_in),
        .bus_out          (bus_out),
        .busy             (busy),
        .done             (done),
        .spi_clk          (spi_clk),
        .spi_ss           (spi_ss),
        .spi_out          (spi_out),
        .spi_in           (spi_in)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Slave: loads its reply when select falls, drives MISO on its shift
    // edges and captures MOSI on its sample edges.
    bit         loop_en     = 1'b0;
    bit         sl_cpha_cfg = 1'b0;
    logic [7:0] sl_tx_cfg   = 8'h00;
    logic       sl_cpha     = 1'b0;
    logic [7:0] sl_tx       = 8'h00;
    logic [7:0] sl_rx       = 8'h00;
    logic [2:0] sl_bit      = 3'd7;
    int         sl_edges    = 0;
    logic       sl_miso     = 1'b0;
    logic       prev_ss     = 1'b1;
    logic       prev_sclk   = 1'b0;

    assign spi_in = loop_en ? spi_out : sl_miso;

    always @(negedge clk) begin
        prev_ss   <= spi_ss;
        prev_sclk <= spi_clk;
        if (spi_ss === 1'b0 && prev_ss === 1'b1) begin
            sl_cpha  <= sl_cpha_cfg;
            sl_tx    <= sl_tx_cfg;
            sl_rx    <= 8'h00;
            sl_bit   <= 3'd7;
            sl_edges <= 0;
            sl_miso  <= sl_tx_cfg[7];
        end else if (spi_ss === 1'b0 && spi_clk !== prev_sclk) begin
            sl_edges <= sl_edges + 1;
            if ((sl_edges % 2 == 0) != sl_cpha) begin
                sl_rx <= {sl_rx[6:0], spi_out};
            end else if (sl_cpha) begin
                sl_miso <= sl_tx[sl_bit];
                sl_bit  <= sl_bit - 3'd1;
            end else if (sl_edges + 1 < 16) begin
                sl_miso <= sl_tx[sl_bit - 3'd1];
                sl_bit  <= sl_bit - 3'd1;
            end
        end
    end

    // Reference model: a transfer is 18 half-periods of H=div+1 enabled
    // cycles; n counts enabled cycles since the accepting edge.
    bit         m_active   = 1'b0;
    bit         m_done     = 1'b0;
    int         m_n        = 0;
    int         m_h        = 1;
    bit         m_cpol     = 1'b0;
    bit         m_cpha     = 1'b0;
    logic [7:0] m_tx       = 8'h00;
    logic [7:0] m_exp      = 8'h00;
    logic [7:0] m_bus_out  = 8'h00;
    logic       m_idle_clk = 1'b0;

    always @(posedge clk) begin
        if (!rst) begin
            m_active   <= 1'b0;
            m_done     <= 1'b0;
            m_bus_out  <= 8'h00;
            m_n        <= 0;
            m_idle_clk <= cpol;
        end else if (ena) begin
            m_done <= 1'b0;
            if (m_active) begin
                if (m_n + 1 == 18 * m_h + 1) begin
                    m_active   <= 1'b0;
                    m_done     <= 1'b1;
                    m_bus_out  <= m_exp;
                    m_idle_clk <= cpol;
                end else begin
                    m_n <= m_n + 1;
                end
            end else begin
                m_idle_clk <= cpol;
                if (start && !m_done) begin
                    m_active <= 1'b1;
                    m_n      <= 1;
                    m_h      <= int'(div) + 1;
                    m_cpol   <= cpol;
                    m_cpha   <= cpha;
                    m_tx     <= bus_in;
                    m_exp    <= loop_en ? bus_in : sl_tx_cfg;
                end
            end
        end
    end

    // SCLK edges completed by cycle n: none during SETUP and the first XFER
    // half-period, then one per half-period, saturating at 16.
    function automatic int edges_done(input int n, input int h);
        int q;
        q = (n - 1) / h - 1;
        if (q < 0) return 0;
        if (q > 16) return 16;
        return q;
    endfunction

    function automatic int mosi_index(input int e, input bit ph);
        if (ph) return (e == 0) ? 7 : 7 - (e - 1) / 2;
        return (e / 2 > 7) ? 0 : 7 - e / 2;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", busy, m_active);
            check("done", done, m_done);
            check("spi_ss", spi_ss, !m_active);
            check("bus_out", bus_out, m_bus_out);
            if (m_active) begin
                check("spi_clk", spi_clk, m_cpol ^ (edges_done(m_n, m_h) % 2 == 1));
                check("spi_out", spi_out, m_tx[mosi_index(edges_done(m_n, m_h), m_cpha)]);
            end else begin
                check("spi_clk idle", spi_clk, m_idle_clk);
                check("spi_out idle", spi_out, 1'b0);
            end
        end
    end

    // Directed transfer with literal expectations; the optional ena gap
    // opens once the slave has seen gap_edge SCLK edges.
    task automatic run_xfer(input string name, input bit p, input bit ph,
                            input logic [7:0] d, input logic [7:0] tx,
                            input logic [7:0] sl_byte, input bit lp,
                            input int gap_edge, input int gap_len,
                            input int exp_lat, input logic [7:0] exp_rx);
        int k;
        int gap_rem;
        bit gapped;
        bit seen;
        tick();
        tick();
        loop_en     = lp;
        sl_cpha_cfg = ph;
        sl_tx_cfg   = sl_byte;
        cpol        = p;
        cpha        = ph;
        div         = d;
        bus_in      = tx;
        start       = 1'b1;
        k = 0;
        gap_rem = 0;
        gapped = 1'b0;
        seen = 1'b0;
        while (k < 3000 && !seen) begin
            tick();
            k++;
            start = 1'b0;
            if (gap_rem > 0) begin
                gap_rem--;
                if (gap_rem == 0) ena = 1'b1;
            end else if (gap_len > 0 && !gapped && spi_ss === 1'b0 && sl_edges >= gap_edge) begin
                ena = 1'b0;
                gap_rem = gap_len;
                gapped = 1'b1;
            end
            if (done === 1'b1) seen = 1'b1;
        end
        ena = 1'b1;
        check({name, " latency"}, k, exp_lat);
        check({name, " bus_out"}, bus_out, exp_rx);
        check({name, " sclk edges"}, sl_edges, 16);
        check({name, " slave rx"}, sl_rx, tx);
        check({name, " sclk idle"}, spi_clk, p);
    endtask

    initial begin : stim
        int         k;
        int         ndone;
        int         run;
        bit         seen;
        bit         p;
        bit         ph;
        bit         lp;
        logic [7:0] d;
        logic [7:0] tx;
        logic [7:0] sb;

        rst    = 1'b0;
        ena    = 1'b1;
        start  = 1'b0;
        cpol   = 1'b0;
        cpha   = 1'b0;
        div    = '0;
        bus_in = 8'h00;
        repeat (3) tick();
        chk_en = 1'b1;

        check("reset spi_ss", spi_ss, 1'b1);
        check("reset busy", busy, 1'b0);
        check("reset bus_out", bus_out, 8'h00);
        check("reset spi_clk", spi_clk, 1'b0);
        cpol = 1'b1;
        tick();
        check("reset spi_clk tracks cpol", spi_clk, 1'b1);

        rst = 1'b1;
        tick();
        cpol = 1'b0;
        tick();
        check("idle spi_clk tracks cpol", spi_clk, 1'b0);

        run_xfer("mode0 div0", 1'b0, 1'b0, 8'd0, 8'hA5, 8'h00, 1'b1, 0, 0, 19, 8'hA5);
        run_xfer("mode3 div3", 1'b1, 1'b1, 8'd3, 8'hC3, 8'h3C, 1'b0, 0, 0, 73, 8'h3C);
        run_xfer("mode1 div1", 1'b0, 1'b1, 8'd1, 8'h5A, 8'h81, 1'b0, 0, 0, 37, 8'h81);
        run_xfer("mode2 div1", 1'b1, 1'b0, 8'd1, 8'h5A, 8'h81, 1'b0, 0, 0, 37, 8'h81);
        run_xfer("ena gap", 1'b0, 1'b0, 8'd1, 8'h96, 8'h00, 1'b1, 5, 10, 47, 8'h96);

        // Reset mid-transfer, at the seventh SCLK edge.
        tick();
        loop_en = 1'b1;
        cpol    = 1'b0;
        cpha    = 1'b0;
        div     = 8'd2;
        bus_in  = 8'h77;
        start   = 1'b1;
        tick();
        start = 1'b0;
        k = 0;
        while (sl_edges < 7 && k < 500) begin
            tick();
            k++;
        end
        check("abort at edge 7", sl_edges, 7);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("abort spi_ss", spi_ss, 1'b1);
        check("abort bus_out", bus_out, 8'h00);
        seen = 1'b0;
        repeat (60) begin
            tick();
            if (done === 1'b1) seen = 1'b1;
        end
        check("abort no done", seen, 1'b0);
        run_xfer("after abort", 1'b0, 1'b0, 8'd2, 8'h3E, 8'hD4, 1'b0, 0, 0, 55, 8'hD4);

        // start held high: each gap is the done cycle plus the accept cycle.
        loop_en = 1'b1;
        cpol    = 1'b1;
        cpha    = 1'b0;
        div     = 8'd0;
        start   = 1'b1;
        ndone   = 0;
        run     = 0;
        k       = 0;
        while (ndone < 3 && k < 500) begin
            bus_in = 8'($urandom);
            tick();
            k++;
            if (spi_ss === 1'b1) begin
                run++;
            end else begin
                if (ndone > 0 && run > 0) check("held start ss gap", run, 2);
                run = 0;
            end
            if (done === 1'b1) ndone++;
        end
        start = 1'b0;
        check("held start transfers", ndone, 3);

        // Randomized transfers with ena gaps, stray starts and input churn.
        repeat (20) begin
            p  = 1'($urandom_range(0, 1));
            ph = 1'($urandom_range(0, 1));
            lp = 1'($urandom_range(0, 1));
            d  = 8'($urandom_range(0, 3));
            tx = 8'($urandom);
            sb = 8'($urandom);
            tick();
            loop_en     = lp;
            sl_cpha_cfg = ph;
            sl_tx_cfg   = sb;
            cpol        = p;
            cpha        = ph;
            div         = d;
            bus_in      = tx;
            start       = 1'b1;
            tick();
            k = 0;
            while (done !== 1'b1 && k < 2000) begin
                if ($urandom_range(0, 3) == 0) begin
                    bus_in = 8'($urandom);
                    div    = 8'($urandom_range(0, 3));
                    cpha   = 1'($urandom_range(0, 1));
                    cpol   = 1'($urandom_range(0, 1));
                end
                ena   = ($urandom_range(0, 7) != 0);
                start = 1'($urandom_range(0, 1));
                tick();
                k++;
            end
            ena   = 1'b1;
            start = 1'b0;
            check("random done reached", done, 1'b1);
            check("random slave rx", sl_rx, tx);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
